// File: rtl/ahb_sram_slave.sv
// AHB responder backed by a word-organised RAM.
// Each accepted address phase is decoded on its own. A legal beat goes to the
// data phase, with optional wait states first. An illegal beat gets a
// two-cycle ERROR response and never touches the RAM.
module ahb_sram_slave #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic          hwrite,
    input  logic [2:0]    hsize,
    input  logic [2:0]    hburst,
    input  logic [3:0]    hprot,
    input  logic [DW-1:0] hwdata,
    input  logic          error,
    output logic [DW-1:0] hrdata,
    output logic          hready,
    output logic [1:0]    hresp
);

    localparam int          IW         = $clog2(DEPTH);
    localparam int unsigned BYTES      = DEPTH * 4;
    localparam logic [3:0]  WS         = 4'(WAIT_STATES);
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t          state_reg, state_next;
    logic [IW+1:0]   addr_reg,  addr_next;
    logic            write_reg, write_next;
    logic [2:0]      size_reg,  size_next;
    logic [3:0]      cnt_reg,   cnt_next;

    logic            slave_ready;
    logic            ignored_ctrl;
    logic            accept;
    logic            acc_err;
    logic [3:0]      lane_en;
    logic            ram_we;
    logic [IW-1:0]   word_idx;
    logic [DW-1:0]   rd_word;

    // The master may only start a new beat while the slave is ready. WAIT and
    // ERR1 are the only cycles that hold the bus.
    assign slave_ready = (state_reg != S_WAIT) && (state_reg != S_ERR1);
    assign hready      = slave_ready;

    // hburst/hprot carry no meaning for this slave. They are reduced into a
    // term that is always true, so the tie-off is visible in the netlist.
    assign ignored_ctrl = (^{hburst, hprot}) | 1'b1;

    assign accept = hsel & htrans[1] & slave_ready & ignored_ctrl;

    // Any one of these conditions turns the accepted beat into an ERROR
    // response. The error state itself records the flag, so nothing extra is
    // kept once the beat has been accepted.
    assign acc_err = error
                   | (haddr >= AW'(BYTES))
                   | (hsize > 3'b010)
                   | ((hsize == 3'b001) & haddr[0])
                   | ((hsize == 3'b010) & (|haddr[1:0]));

    // State and transfer registers; reset abandons any beat in flight
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_reg <= S_IDLE;
            addr_reg  <= '0;
            write_reg <= 1'b0;
            size_reg  <= 3'b000;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            write_reg <= write_next;
            size_reg  <= size_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state decode and response; a fresh accept overrides the default return to IDLE
    always_comb begin
        state_next = S_IDLE;
        addr_next  = addr_reg;
        write_next = write_reg;
        size_next  = size_reg;
        cnt_next   = cnt_reg;
        hresp      = RESP_OKAY;

        case (state_reg)
            S_WAIT: begin
                // Stop at zero instead of wrapping. The last wait cycle hands over to DATA.
                if (cnt_reg > 4'd1) begin
                    cnt_next   = cnt_reg - 4'd1;
                    state_next = S_WAIT;
                end else begin
                    cnt_next   = 4'd0;
                    state_next = S_DATA;
                end
            end
            S_ERR1: begin
                hresp      = RESP_ERROR;
                state_next = S_ERR2;
            end
            S_ERR2: begin
                hresp      = RESP_ERROR;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (accept) begin
            addr_next  = haddr[IW+1:0];
            write_next = hwrite;
            size_next  = hsize;
            cnt_next   = WS;
            if (acc_err) begin
                state_next = S_ERR1;
            end else if (WS != 4'd0) begin
                state_next = S_WAIT;
            end else begin
                state_next = S_DATA;
            end
        end
    end

    // Little-endian byte-lane selection for the registered size/offset
    always_comb begin
        case (size_reg)
            3'b000:  lane_en = 4'b0001 << addr_reg[1:0];
            3'b001:  lane_en = addr_reg[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    assign word_idx = addr_reg[IW+1:2];
    assign ram_we   = (state_reg == S_DATA) && write_reg;

    // One byte-wide RAM per lane. A write lands on the edge that ends DATA.
    // The read is asynchronous, so a read beat that directly follows a write
    // to the same word sees the new data in its own DATA cycle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];

            // Byte-lane write, enabled only in a legal write data phase
            always_ff @(posedge hclk) begin
                if (ram_we && lane_en[gi]) begin
                    mem_lane[word_idx] <= hwdata[8*gi +: 8];
                end
            end

            assign rd_word[8*gi +: 8] = mem_lane[word_idx];
        end
    endgenerate

    assign hrdata = ((state_reg == S_DATA) && !write_reg) ? rd_word : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave. One instance runs with zero wait states
// and one with three. Outputs are checked on the falling edge after each driven cycle.
module tb_ahb_sram_slave;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;
    localparam logic [2:0] SZ_B   = 3'b000;
    localparam logic [2:0] SZ_H   = 3'b001;
    localparam logic [2:0] SZ_W   = 3'b010;
    localparam logic       D0     = 1'b0;
    localparam logic       D3     = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              hresetn;
    logic [1:0]        hsel_v;
    logic [1:0]        hwrite_v;
    logic [1:0]        err_v;
    logic [1:0][1:0]   htrans_v;
    logic [1:0][2:0]   hsize_v;
    logic [1:0][2:0]   hburst_v;
    logic [1:0][3:0]   hprot_v;
    logic [1:0][31:0]  haddr_v;
    logic [1:0][31:0]  hwdata_v;
    logic [2:0]        burst_now = 3'b000;

    logic [31:0] hrdata0, hrdata3;
    logic        hready0, hready3;
    logic [1:0]  hresp0,  hresp3;

    int vectors     = 0;
    int miscompares = 0;

    ahb_sram_slave #(.AW(32), .DW(32), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .hclk(clk), .hresetn(hresetn), .hsel(hsel_v[0]), .haddr(haddr_v[0]),
        .htrans(htrans_v[0]), .hwrite(hwrite_v[0]), .hsize(hsize_v[0]),
        .hburst(hburst_v[0]), .hprot(hprot_v[0]), .hwdata(hwdata_v[0]),
        .error(err_v[0]), .hrdata(hrdata0), .hready(hready0), .hresp(hresp0)
    );

    ahb_sram_slave #(.AW(32), .DW(32), .DEPTH(256), .WAIT_STATES(3)) u_dut3 (
        .hclk(clk), .hresetn(hresetn), .hsel(hsel_v[1]), .haddr(haddr_v[1]),
        .htrans(htrans_v[1]), .hwrite(hwrite_v[1]), .hsize(hsize_v[1]),
        .hburst(hburst_v[1]), .hprot(hprot_v[1]), .hwdata(hwdata_v[1]),
        .error(err_v[1]), .hrdata(hrdata3), .hready(hready3), .hresp(hresp3)
    );

    // Drive one cycle: next address phase plus hwdata for the current data phase
    task automatic cyc(input logic d, input logic sel, input logic [1:0] trans,
                       input logic wr, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic er);
        hsel_v[d]   = sel;
        htrans_v[d] = trans;
        hwrite_v[d] = wr;
        hsize_v[d]  = size;
        haddr_v[d]  = addr;
        hwdata_v[d] = wdata;
        err_v[d]    = er;
        hburst_v[d] = burst_now;
        hprot_v[d]  = 4'b0011;
        @(negedge clk);
    endtask

    task automatic chk(input logic d, input string tag, input logic exp_rdy,
                       input logic [1:0] exp_resp, input logic [31:0] exp_data);
        logic [34:0] obs;
        logic [34:0] expv;
        obs  = (d == D0) ? {hready0, hresp0, hrdata0} : {hready3, hresp3, hrdata3};
        expv = {exp_rdy, exp_resp, exp_data};
        vectors++;
        $display("vec %0d %s: ready=%0b resp=%b rdata=%h", vectors, tag,
                 obs[34], obs[33:32], obs[31:0]);
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed ready=%0b resp=%b rdata=%h, expected ready=%0b resp=%b rdata=%h",
                   tag, obs[34], obs[33:32], obs[31:0], exp_rdy, exp_resp, exp_data);
        end
    endtask

    task automatic idle(input logic d, input string tag);
        cyc(d, 1'b0, T_IDLE, 1'b0, SZ_W, 32'h0, 32'h0, 1'b0);
        chk(d, tag, 1'b1, 2'b00, 32'h0);
    endtask

    // Full word write through the three-wait-state instance
    task automatic ws3_write(input logic [31:0] addr, input logic [31:0] data, input string tag);
        cyc(D3, 1'b1, T_NSEQ, 1'b1, SZ_W, addr, 32'h0, 1'b0);
        chk(D3, {tag, "_wait1"}, 1'b0, 2'b00, 32'h0);
        cyc(D3, 1'b0, T_IDLE, 1'b0, SZ_W, 32'h0, data, 1'b0);
        chk(D3, {tag, "_wait2"}, 1'b0, 2'b00, 32'h0);
        cyc(D3, 1'b0, T_IDLE, 1'b0, SZ_W, 32'h0, data, 1'b0);
        chk(D3, {tag, "_wait3"}, 1'b0, 2'b00, 32'h0);
        cyc(D3, 1'b0, T_IDLE, 1'b0, SZ_W, 32'h0, data, 1'b0);
        chk(D3, {tag, "_data"}, 1'b1, 2'b00, 32'h0);
        cyc(D3, 1'b0, T_IDLE, 1'b0, SZ_W, 32'h0, data, 1'b0);
        chk(D3, {tag, "_idle"}, 1'b1, 2'b00, 32'h0);
    endtask

    // Word read through the three-wait-state instance: three low cycles, then data
    task automatic ws3_read(input logic [31:0] addr, input logic [31:0] expd, input string tag);
        cyc(D3, 1'b1, T_NSEQ, 1'b0, SZ_W, addr, 32'h0, 1'b0);
        chk(D3, {tag, "_wait1"}, 1'b0, 2'b00, 32'h0);
        cyc(D3, 1'b0, T_IDLE, 1'b0, SZ_W, 32'h0, 32'h0, 1'b0);
        chk(D3, {tag, "_wait2"}, 1'b0, 2'b00, 32'h0);
        cyc(D3, 1'b0, T_IDLE, 1'b0, SZ_W, 32'h0, 32'h0, 1'b0);
        chk(D3, {tag, "_wait3"}, 1'b0, 2'b00, 32'h0);
        cyc(D3, 1'b0, T_IDLE, 1'b0, SZ_W, 32'h0, 32'h0, 1'b0);
        chk(D3, {tag, "_data"}, 1'b1, 2'b00, expd);
        idle(D3, {tag, "_idle"});
    endtask

    // Watchdog: the directed sequence is a few hundred cycles long
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach summary, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        hresetn  = 1'b1;
        hsel_v   = '0;
        hwrite_v = '0;
        err_v    = '0;
        htrans_v = '0;
        hsize_v  = '0;
        hburst_v = '0;
        hprot_v  = '0;
        haddr_v  = '0;
        hwdata_v = '0;
        #2 hresetn = 1'b0;
        #1;
        chk(D0, "reset_ws0", 1'b1, 2'b00, 32'h0);
        chk(D3, "reset_ws3", 1'b1, 2'b00, 32'h0);
        repeat (2) @(negedge clk);
        hresetn = 1'b1;

        // Write then read the same word back-to-back at zero waits
        cyc(D0, 1'b1, T_NSEQ, 1'b1, SZ_W, 32'h10, 32'h0, 1'b0);
        chk(D0, "wr10_dphase", 1'b1, 2'b00, 32'h0);
        cyc(D0, 1'b1, T_NSEQ, 1'b0, SZ_W, 32'h10, 32'hDEADBEEF, 1'b0);
        chk(D0, "rd10_data", 1'b1, 2'b00, 32'hDEADBEEF);
        idle(D0, "idle_after_rd10");

        // Byte lane then halfword lane merges into 0x11223344
        cyc(D0, 1'b1, T_NSEQ, 1'b1, SZ_W, 32'h10, 32'h0, 1'b0);
        chk(D0, "wr10_word_dphase", 1'b1, 2'b00, 32'h0);
        cyc(D0, 1'b1, T_NSEQ, 1'b1, SZ_B, 32'h11, 32'h11223344, 1'b0);
        chk(D0, "wr11_byte_dphase", 1'b1, 2'b00, 32'h0);
        cyc(D0, 1'b1, T_NSEQ, 1'b0, SZ_W, 32'h10, 32'h0000AA00, 1'b0);
        chk(D0, "rd10_after_byte", 1'b1, 2'b00, 32'h1122AA44);
        cyc(D0, 1'b1, T_NSEQ, 1'b1, SZ_H, 32'h12, 32'h0, 1'b0);
        chk(D0, "wr12_half_dphase", 1'b1, 2'b00, 32'h0);
        cyc(D0, 1'b1, T_NSEQ, 1'b0, SZ_W, 32'h10, 32'h55660000, 1'b0);
        chk(D0, "rd10_after_half", 1'b1, 2'b00, 32'h5566AA44);
        idle(D0, "idle_after_lanes");

        // INCR4 write burst: four address phases plus one trailing data phase
        burst_now = 3'b011;
        cyc(D0, 1'b1, T_NSEQ, 1'b1, SZ_W, 32'h0, 32'h0, 1'b0);
        chk(D0, "bw_beat0", 1'b1, 2'b00, 32'h0);
        cyc(D0, 1'b1, T_SEQ, 1'b1, SZ_W, 32'h4, 32'h01020304, 1'b0);
        chk(D0, "bw_beat1", 1'b1, 2'b00, 32'h0);
        cyc(D0, 1'b1, T_SEQ, 1'b1, SZ_W, 32'h8, 32'h05060708, 1'b0);
        chk(D0, "bw_beat2", 1'b1, 2'b00, 32'h0);
        cyc(D0, 1'b1, T_SEQ, 1'b1, SZ_W, 32'hC, 32'h090A0B0C, 1'b0);
        chk(D0, "bw_beat3", 1'b1, 2'b00, 32'h0);
        burst_now = 3'b000;
        cyc(D0, 1'b0, T_IDLE, 1'b0, SZ_W, 32'h0, 32'h0D0E0F10, 1'b0);
        chk(D0, "bw_done", 1'b1, 2'b00, 32'h0);

        // Read burst back, with a BUSY beat inserted
        burst_now = 3'b011;
        cyc(D0, 1'b1, T_NSEQ, 1'b0, SZ_W, 32'h0, 32'h0, 1'b0);
        chk(D0, "br_beat0", 1'b1, 2'b00, 32'h01020304);
        cyc(D0, 1'b1, T_BUSY, 1'b0, SZ_W, 32'h4, 32'h0, 1'b0);
        chk(D0, "br_busy", 1'b1, 2'b00, 32'h0);
        cyc(D0, 1'b1, T_SEQ, 1'b0, SZ_W, 32'h4, 32'h0, 1'b0);
        chk(D0, "br_beat1", 1'b1, 2'b00, 32'h05060708);
        cyc(D0, 1'b1, T_SEQ, 1'b0, SZ_W, 32'h8, 32'h0, 1'b0);
        chk(D0, "br_beat2", 1'b1, 2'b00, 32'h090A0B0C);
        cyc(D0, 1'b1, T_SEQ, 1'b0, SZ_W, 32'hC, 32'h0, 1'b0);
        chk(D0, "br_beat3", 1'b1, 2'b00, 32'h0D0E0F10);
        burst_now = 3'b000;
        idle(D0, "idle_after_br");

        // Pipelined write then read of word 0
        cyc(D0, 1'b1, T_NSEQ, 1'b1, SZ_W, 32'h0, 32'h0, 1'b0);
        chk(D0, "raw0_wr_dphase", 1'b1, 2'b00, 32'h0);
        cyc(D0, 1'b1, T_NSEQ, 1'b0, SZ_W, 32'h0, 32'hCAFEF00D, 1'b0);
        chk(D0, "raw0_rd", 1'b1, 2'b00, 32'hCAFEF00D);
        idle(D0, "idle_after_raw");

        // Last legal word
        cyc(D0, 1'b1, T_NSEQ, 1'b1, SZ_W, 32'h3FC, 32'h0, 1'b0);
        chk(D0, "wr3fc_dphase", 1'b1, 2'b00, 32'h0);
        cyc(D0, 1'b1, T_NSEQ, 1'b0, SZ_W, 32'h3FC, 32'hA5A55A5A, 1'b0);
        chk(D0, "rd3fc", 1'b1, 2'b00, 32'hA5A55A5A);
        idle(D0, "idle_after_3fc");

        // Out-of-range read; the NONSEQ driven during ERR1 must be ignored
        cyc(D0, 1'b1, T_NSEQ, 1'b0, SZ_W, 32'h400, 32'h0, 1'b0);
        chk(D0, "e400_err1", 1'b0, 2'b01, 32'h0);
        cyc(D0, 1'b1, T_NSEQ, 1'b0, SZ_W, 32'h10, 32'h0, 1'b0);
        chk(D0, "e400_err2", 1'b1, 2'b01, 32'h0);
        idle(D0, "idle_after_e400");

        // Misaligned halfword write; ERR2 accepts a read of the same word
        cyc(D0, 1'b1, T_NSEQ, 1'b1, SZ_H, 32'h1, 32'h0, 1'b0);
        chk(D0, "eh01_err1", 1'b0, 2'b01, 32'h0);
        cyc(D0, 1'b0, T_IDLE, 1'b0, SZ_W, 32'h0, 32'hFFFFFFFF, 1'b0);
        chk(D0, "eh01_err2", 1'b1, 2'b01, 32'h0);
        cyc(D0, 1'b1, T_NSEQ, 1'b0, SZ_W, 32'h0, 32'hFFFFFFFF, 1'b0);
        chk(D0, "rd0_after_eh01", 1'b1, 2'b00, 32'hCAFEF00D);
        idle(D0, "idle_after_eh01");

        // Forced error on an otherwise legal write
        cyc(D0, 1'b1, T_NSEQ, 1'b1, SZ_W, 32'h10, 32'h0, 1'b1);
        chk(D0, "eforce_err1", 1'b0, 2'b01, 32'h0);
        cyc(D0, 1'b0, T_IDLE, 1'b0, SZ_W, 32'h0, 32'hFFFFFFFF, 1'b0);
        chk(D0, "eforce_err2", 1'b1, 2'b01, 32'h0);
        cyc(D0, 1'b1, T_NSEQ, 1'b0, SZ_W, 32'h10, 32'hFFFFFFFF, 1'b0);
        chk(D0, "rd10_after_eforce", 1'b1, 2'b00, 32'h5566AA44);
        idle(D0, "idle_after_eforce");

        // Oversized transfer
        cyc(D0, 1'b1, T_NSEQ, 1'b0, 3'b011, 32'h10, 32'h0, 1'b0);
        chk(D0, "esize_err1", 1'b0, 2'b01, 32'h0);
        cyc(D0, 1'b0, T_IDLE, 1'b0, SZ_W, 32'h0, 32'h0, 1'b0);
        chk(D0, "esize_err2", 1'b1, 2'b01, 32'h0);
        idle(D0, "idle_after_esize");

        // Three wait states: write then read @0x20
        ws3_write(32'h20, 32'h12345678, "ws3_wr20");
        ws3_read(32'h20, 32'h12345678, "ws3_rd20");

        // Reset during a WAIT of a write to 0x30 leaves the old contents
        ws3_write(32'h30, 32'h0BADF00D, "ws3_wr30");
        cyc(D3, 1'b1, T_NSEQ, 1'b1, SZ_W, 32'h30, 32'h0, 1'b0);
        chk(D3, "rst30_wait1", 1'b0, 2'b00, 32'h0);
        cyc(D3, 1'b0, T_IDLE, 1'b0, SZ_W, 32'h0, 32'hFFFFFFFF, 1'b0);
        chk(D3, "rst30_wait2", 1'b0, 2'b00, 32'h0);
        hresetn = 1'b0;
        #1;
        chk(D3, "rst30_async", 1'b1, 2'b00, 32'h0);
        @(negedge clk);
        chk(D3, "rst30_held", 1'b1, 2'b00, 32'h0);
        hresetn = 1'b1;
        cyc(D3, 1'b0, T_IDLE, 1'b0, SZ_W, 32'h0, 32'hFFFFFFFF, 1'b0);
        chk(D3, "rst30_idle", 1'b1, 2'b00, 32'h0);
        ws3_read(32'h30, 32'h0BADF00D, "ws3_rd30");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
